alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised-width ALU that replaces the fixed 64-bit combinational ALU in the execute stage. Keeps all 16 original operations (one-cycle registered result) and adds iterative multiply and divide, so it sits behind a valid/ready handshake. The execute stage issues one operation at a time; the block holds its result until the consumer takes it.

## Interface
- WIDTH, 64, operand/result width in bits; legal values are 8 or more.
- SHAMT_W, $clog2(WIDTH), derived shift-amount width; not overridden.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation this cycle
- opcode  in  5  operation select
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  operation result
- cout  out  1  carry flag
- zero  out  1  result == 0
- illegal  out  1  opcode not implemented

## Operation
- Opcodes 0x00–0x0F are the original set:
  - ADD, SUB, AND, OR, NOR, XOR, XNOR, NAND
  - PASSA, PASSB, ZERO
  - SLT (signed), SLTU
  - SLL, SRL, SRA; shift amount is B[SHAMT_W-1:0].
- New opcodes:
  - 0x10 MUL: low WIDTH bits of A*B.
  - 0x11 MULHU: high WIDTH bits, unsigned.
  - 0x12 DIVU: quotient.
  - 0x13 REMU: remainder.
- Opcodes 0x14–0x1F: illegal=1, result=0, one-cycle completion.
- cout:
  - ADD: carry out of A+B.
  - SUB: carry out of A+~B+1 (1 = no borrow).
  - All other ops: 0.
- zero = (result == 0), registered together with result.
- States:
  - IDLE: in_ready=1.
  - CALC: iterating; in_ready=0, out_valid=0.
  - DONE: out_valid=1.
- Transitions:
  - Accept (in_valid && in_ready) with a one-cycle op: go to DONE.
  - Accept with an iterative op: go to CALC.
  - CALC: go to DONE after the last iteration.
  - DONE with out_ready: go to IDLE, or directly to DONE/CALC if a new operation is accepted the same cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Operands and opcode are captured at acceptance. A/B changes afterwards have no effect.
- MUL/MULHU: radix-2 shift-add, one bit per cycle, WIDTH iterations, 2*WIDTH-bit accumulator.
- DIVU/REMU: restoring division, one quotient bit per cycle, WIDTH iterations.
- Divide by zero: DIVU returns all ones and REMU returns A. No iteration; completes like a one-cycle op.
- In DONE, result and flags are held stable until out_ready.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, cout 0, zero 0, illegal 0; iteration counter 0.
- One-cycle ops: result registered at the acceptance edge; out_valid high the cycle after acceptance.
- Iterative ops: out_valid rises exactly WIDTH cycles after the acceptance cycle (64 for WIDTH=64).
- Back-to-back one-cycle ops with out_ready held high: one result per cycle.
- Reset mid-CALC or mid-DONE: aborts the operation and discards the result. All outputs take their reset values on the next cycle.
- in_valid while in_ready=0 is ignored; the producer must hold the request.

## Configuration
- ALU_DIV_EN defined: the divider is built; DIVU/REMU behave as above.
- ALU_DIV_EN undefined: no divider logic. DIVU/REMU complete in one cycle with result=0, cout=0 and illegal=1.

## Test plan
- ADD, A=0x7FFF_FFFF_FFFF_FFFF, B=0x20 -> result 0x8000_0000_0000_001F, cout 0, zero 0, out_valid one cycle after accept. Sweep all 16 legacy opcodes with the same operands.
- MUL 0xFFFF_FFFF × 0xFFFF_FFFF -> 0xFFFF_FFFE_0000_0001 exactly 64 cycles after accept, in_ready 0 throughout. MULHU all-ones × 2 -> 0x1.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU x/0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 5/0 -> 5, one-cycle latency.
- out_ready held low 5 cycles in DONE -> result and out_valid stable, in_ready 0. ADD offered in the same cycle out_ready rises is accepted.
- rst asserted at iteration 10 of MUL -> next cycle out_valid 0, in_ready 1, result 0. A following ADD 1+1 returns 2.
- ALU_DIV_EN undefined -> DIVU 100/7 gives illegal 1, result 0, one-cycle latency. Opcode 0x1F gives illegal 1 in both builds.

Source files
------------

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- multi-cycle, parametrised-width ALU for the execute stage.
//
// The 16 original operations complete in one cycle with a registered result.
// MUL/MULHU use a radix-2 shift-add multiplier and DIVU/REMU a restoring
// divider. Both retire one bit per cycle, so the block sits behind a
// valid/ready handshake and issues one operation at a time.
//
// Handshake: an operation is accepted on a rising edge where
// in_valid && in_ready. A result is offered while out_valid is high and is
// consumed on a rising edge where out_valid && out_ready. result, cout, zero
// and illegal stay stable while out_valid is high and out_ready is low. A
// request offered while in_ready is low is ignored, so the producer holds it.
//
// Configuration macro: ALU_DIV_EN
//   defined   : the restoring divider is built and DIVU/REMU are iterative.
//   undefined : no divider logic. DIVU/REMU finish in one cycle with
//               result=0, cout=0 and illegal=1.
//
// Parameters:
//   WIDTH    operand/result width in bits (8 or more)
//   SHAMT_W  shift-amount width, derived from WIDTH
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   operation offered
//   in_ready   out  block can accept an operation this cycle
//   opcode     in   [4:0] operation select
//   A, B       in   [WIDTH-1:0] operands, captured at acceptance
//   out_valid  out  result valid
//   out_ready  in   consumer takes the result
//   result     out  [WIDTH-1:0] operation result
//   cout       out  carry flag (ADD carry, SUB no-borrow, else 0)
//   zero       out  result == 0
//   illegal    out  opcode is 0x14-0x1F, or DIVU/REMU without the divider
// -----------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             illegal
);

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_AND   = 5'h02;
    localparam logic [4:0] OP_OR    = 5'h03;
    localparam logic [4:0] OP_NOR   = 5'h04;
    localparam logic [4:0] OP_XOR   = 5'h05;
    localparam logic [4:0] OP_XNOR  = 5'h06;
    localparam logic [4:0] OP_NAND  = 5'h07;
    localparam logic [4:0] OP_PASSA = 5'h08;
    localparam logic [4:0] OP_PASSB = 5'h09;
    localparam logic [4:0] OP_ZERO  = 5'h0A;
    localparam logic [4:0] OP_SLT   = 5'h0B;
    localparam logic [4:0] OP_SLTU  = 5'h0C;
    localparam logic [4:0] OP_SLL   = 5'h0D;
    localparam logic [4:0] OP_SRL   = 5'h0E;
    localparam logic [4:0] OP_SRA   = 5'h0F;
    localparam logic [4:0] OP_MUL   = 5'h10;
    localparam logic [4:0] OP_MULHU = 5'h11;
    localparam logic [4:0] OP_DIVU  = 5'h12;
    localparam logic [4:0] OP_REMU  = 5'h13;

    // Low two opcode bits identify the iterative op once captured.
    localparam logic [1:0] IOP_MUL   = 2'd0;
    localparam logic [1:0] IOP_MULHU = 2'd1;
    localparam logic [1:0] IOP_DIVU  = 2'd2;
    localparam logic [1:0] IOP_REMU  = 2'd3;

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);
    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Iteration datapath registers.
    // MUL: acc = {partial product, remaining multiplier bits}, opb = multiplicand.
    // DIV: acc = {partial remainder, dividend/quotient bits}, opb = divisor.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [1:0]         iop;
    logic [SHAMT_W-1:0] cnt;

    logic               accept;
    logic               is_iter;
    logic               last_iter;

    logic [WIDTH-1:0]   fast_res;
    logic               fast_cout;
    logic               fast_ill;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [SHAMT_W-1:0] sha;

    logic [2*WIDTH-1:0] acc_in;
    logic [WIDTH-1:0]   opb_in;
    logic [1:0]         iop_in;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   iter_res;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;
`endif

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt == CNT_LAST);

    // ---------------------------------------------------------------------
    // One-cycle operations, evaluated on the live operands at acceptance
    // ---------------------------------------------------------------------
    assign sha      = B[SHAMT_W-1:0];
    assign add_full = {1'b0, A} + {1'b0, B};
    // A + ~B + 1: the carry out is 1 when no borrow occurs.
    assign sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        fast_res  = '0;
        fast_cout = 1'b0;
        fast_ill  = 1'b0;
        case (opcode)
            OP_ADD: begin
                fast_res  = add_full[WIDTH-1:0];
                fast_cout = add_full[WIDTH];
            end
            OP_SUB: begin
                fast_res  = sub_full[WIDTH-1:0];
                fast_cout = sub_full[WIDTH];
            end
            OP_AND:   fast_res = A & B;
            OP_OR:    fast_res = A | B;
            OP_NOR:   fast_res = ~(A | B);
            OP_XOR:   fast_res = A ^ B;
            OP_XNOR:  fast_res = ~(A ^ B);
            OP_NAND:  fast_res = ~(A & B);
            OP_PASSA: fast_res = A;
            OP_PASSB: fast_res = B;
            OP_ZERO:  fast_res = '0;
            OP_SLT:   fast_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:  fast_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:   fast_res = A << sha;
            OP_SRL:   fast_res = A >> sha;
            OP_SRA:   fast_res = WIDTH'($signed(A) >>> sha);
            // Multiplies always iterate; this path is never registered for them.
            OP_MUL, OP_MULHU: fast_res = '0;
`ifdef ALU_DIV_EN
            // Only reached with B == 0: nonzero divisors iterate instead.
            OP_DIVU: fast_res = '1;
            OP_REMU: fast_res = A;
`else
            OP_DIVU, OP_REMU: fast_ill = 1'b1;
`endif
            default:  fast_ill = 1'b1;
        endcase
    end

    always_comb begin
        is_iter = (opcode == OP_MUL) || (opcode == OP_MULHU);
`ifdef ALU_DIV_EN
        if (((opcode == OP_DIVU) || (opcode == OP_REMU)) && (B != '0)) begin
            is_iter = 1'b1;
        end
`endif
    end

    // ---------------------------------------------------------------------
    // Iteration step. The acceptance edge performs the first step straight
    // from A/B, which makes out_valid rise exactly WIDTH cycles after accept.
    // ---------------------------------------------------------------------
    always_comb begin
        acc_in = acc;
        opb_in = opb;
        iop_in = iop;
        if (state != CALC) begin
            iop_in = opcode[1:0];
            opb_in = A;
            acc_in = {{WIDTH{1'b0}}, B};
`ifdef ALU_DIV_EN
            if (opcode[1]) begin
                opb_in = B;
                acc_in = {{WIDTH{1'b0}}, A};
            end
`endif
        end
    end

    always_comb begin
        // Shift-add: add the multiplicand when the current multiplier bit is
        // set, then shift the whole accumulator right, carry included.
        mul_sum  = {1'b0, acc_in[2*WIDTH-1:WIDTH]} +
                   (acc_in[0] ? {1'b0, opb_in} : {(WIDTH+1){1'b0}});
        acc_step = {mul_sum, acc_in[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        // Restoring: bring down the next dividend bit and try a subtract. The
        // trial value is WIDTH+1 bits because 2*rem+1 can exceed WIDTH bits.
        div_part = acc_in[2*WIDTH-1:WIDTH-1];
        div_diff = div_part - {1'b0, opb_in};
        if (iop_in[1]) begin
            if (div_diff[WIDTH]) begin
                acc_step = {acc_in[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_step = {div_diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            end
        end
`endif
    end

    always_comb begin
        case (iop)
            IOP_MUL:   iter_res = acc_step[WIDTH-1:0];
            IOP_MULHU: iter_res = acc_step[2*WIDTH-1:WIDTH];
            IOP_DIVU:  iter_res = acc_step[WIDTH-1:0];
            IOP_REMU:  iter_res = acc_step[2*WIDTH-1:WIDTH];
            default:   iter_res = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = is_iter ? CALC : DONE;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_next = is_iter ? CALC : DONE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            opb     <= '0;
            iop     <= '0;
            cnt     <= '0;
            result  <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (accept) begin
            if (is_iter) begin
                acc <= acc_step;
                opb <= opb_in;
                iop <= iop_in;
                cnt <= CNT_ONE;
            end else begin
                result  <= fast_res;
                cout    <= fast_cout;
                zero    <= (fast_res == '0);
                illegal <= fast_ill;
            end
        end else if (state == CALC) begin
            acc <= acc_step;
            if (last_iter) begin
                cnt     <= '0;
                result  <= iter_res;
                cout    <= 1'b0;
                zero    <= (iter_res == '0);
                illegal <= 1'b0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc -- directed self-checking bench for alu_mc at WIDTH=64.
// Expectations for DIVU/REMU follow the ALU_DIV_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_alu_mc;

    localparam int W = 64;

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_MUL   = 5'h10;
    localparam logic [4:0] OP_MULHU = 5'h11;
    localparam logic [4:0] OP_DIVU  = 5'h12;
    localparam logic [4:0] OP_REMU  = 5'h13;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   opcode;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         illegal;

    int n_checks;
    int n_pass;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .illegal   (illegal)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks (called at a negedge) ----------------
    // Offers one operation, scrambles A/B after acceptance, then waits until
    // out_valid. lat counts cycles from acceptance; busy_ok drops if in_ready
    // was seen high while the result was pending.
    task automatic issue(input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int lat, output logic busy_ok);
        int k;
        busy_ok = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        opcode   = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        A        = {$urandom, $urandom};
        B        = {$urandom, $urandom};
        lat      = 1;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, result, cout, zero, illegal} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000})
            $display("FAIL reset: got rdy=%b vld=%b res=%h c=%b z=%b il=%b, want rdy=1 vld=0 res=0 c=0 z=0 il=0",
                     in_ready, out_valid, result, cout, zero, illegal);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_legacy();
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic [W-1:0] er[16];
        logic         ec[16];
        int           lat;
        logic         bo;
        a0 = 64'h7FFF_FFFF_FFFF_FFFF;
        b0 = 64'h0000_0000_0000_0020;
        er[0]  = 64'h8000_0000_0000_001F; ec[0]  = 1'b0; // ADD
        er[1]  = 64'h7FFF_FFFF_FFFF_FFDF; ec[1]  = 1'b1; // SUB, no borrow
        er[2]  = 64'h0000_0000_0000_0020; ec[2]  = 1'b0; // AND
        er[3]  = 64'h7FFF_FFFF_FFFF_FFFF; ec[3]  = 1'b0; // OR
        er[4]  = 64'h8000_0000_0000_0000; ec[4]  = 1'b0; // NOR
        er[5]  = 64'h7FFF_FFFF_FFFF_FFDF; ec[5]  = 1'b0; // XOR
        er[6]  = 64'h8000_0000_0000_0020; ec[6]  = 1'b0; // XNOR
        er[7]  = 64'hFFFF_FFFF_FFFF_FFDF; ec[7]  = 1'b0; // NAND
        er[8]  = 64'h7FFF_FFFF_FFFF_FFFF; ec[8]  = 1'b0; // PASSA
        er[9]  = 64'h0000_0000_0000_0020; ec[9]  = 1'b0; // PASSB
        er[10] = 64'h0000_0000_0000_0000; ec[10] = 1'b0; // ZERO
        er[11] = 64'h0000_0000_0000_0000; ec[11] = 1'b0; // SLT
        er[12] = 64'h0000_0000_0000_0000; ec[12] = 1'b0; // SLTU
        er[13] = 64'hFFFF_FFFF_0000_0000; ec[13] = 1'b0; // SLL 32
        er[14] = 64'h0000_0000_7FFF_FFFF; ec[14] = 1'b0; // SRL 32
        er[15] = 64'h0000_0000_7FFF_FFFF; ec[15] = 1'b0; // SRA 32
        for (int i = 0; i < 16; i++) begin
            issue(5'(i), a0, b0, lat, bo);
            n_checks++;
            if ({result, cout, zero, illegal} !== {er[i], ec[i], (er[i] == '0), 1'b0} || lat != 1)
                $display("FAIL legacy op=%0h: got res=%h c=%b z=%b il=%b lat=%0d, want res=%h c=%b z=%b il=0 lat=1",
                         i, result, cout, zero, illegal, lat, er[i], ec[i], (er[i] == '0));
            else n_pass++;
            consume();
        end
        // Signed vs unsigned compare with a negative operand, and an SRA sign fill.
        issue(5'h0B, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat, bo);
        n_checks++;
        if (result !== 64'h1) $display("FAIL slt_neg: got %h want 1", result);
        else n_pass++;
        consume();
        issue(5'h0C, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat, bo);
        n_checks++;
        if (result !== 64'h0 || zero !== 1'b1) $display("FAIL sltu_big: got res=%h z=%b want 0 z=1", result, zero);
        else n_pass++;
        consume();
        issue(5'h0F, 64'h8000_0000_0000_0000, 64'h4, lat, bo);
        n_checks++;
        if (result !== 64'hF800_0000_0000_0000) $display("FAIL sra_neg: got %h want f800000000000000", result);
        else n_pass++;
        consume();
    endtask

    task automatic test_mul();
        int   lat;
        logic bo;
        issue(OP_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, lat, bo);
        n_checks++;
        if ({result, cout, zero, illegal} !== {64'hFFFF_FFFE_0000_0001, 3'b000} || lat != 64 || bo !== 1'b1)
            $display("FAIL mul32sq: got res=%h c=%b z=%b il=%b lat=%0d busy_ok=%b, want fffffffe00000001 0 0 0 lat=64 busy_ok=1",
                     result, cout, zero, illegal, lat, bo);
        else n_pass++;
        consume();
        issue(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, lat, bo);
        n_checks++;
        if (result !== 64'h1 || lat != 64)
            $display("FAIL mulhu: got res=%h lat=%0d, want 1 lat=64", result, lat);
        else n_pass++;
        consume();
        issue(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, lat, bo);
        n_checks++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFFE || lat != 64)
            $display("FAIL mul_low: got res=%h lat=%0d, want fffffffffffffffe lat=64", result, lat);
        else n_pass++;
        consume();
        issue(OP_MUL, 64'h1234, 64'h0, lat, bo);
        n_checks++;
        if (result !== 64'h0 || zero !== 1'b1)
            $display("FAIL mul_zero: got res=%h z=%b, want 0 z=1", result, zero);
        else n_pass++;
        consume();
    endtask

    task automatic test_div();
        int   lat;
        logic bo;
`ifdef ALU_DIV_EN
        issue(OP_DIVU, 64'd100, 64'd7, lat, bo);
        n_checks++;
        if (result !== 64'd14 || illegal !== 1'b0 || lat != 64 || bo !== 1'b1)
            $display("FAIL divu: got res=%h il=%b lat=%0d busy_ok=%b, want 14 il=0 lat=64 busy_ok=1", result, illegal, lat, bo);
        else n_pass++;
        consume();
        issue(OP_REMU, 64'd100, 64'd7, lat, bo);
        n_checks++;
        if (result !== 64'd2 || lat != 64)
            $display("FAIL remu: got res=%h lat=%0d, want 2 lat=64", result, lat);
        else n_pass++;
        consume();
        issue(OP_DIVU, 64'h0123, 64'd0, lat, bo);
        n_checks++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFFF || illegal !== 1'b0 || lat != 1)
            $display("FAIL divu_by0: got res=%h il=%b lat=%0d, want ffffffffffffffff il=0 lat=1", result, illegal, lat);
        else n_pass++;
        consume();
        issue(OP_REMU, 64'd5, 64'd0, lat, bo);
        n_checks++;
        if (result !== 64'd5 || lat != 1)
            $display("FAIL remu_by0: got res=%h lat=%0d, want 5 lat=1", result, lat);
        else n_pass++;
        consume();
        issue(OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, lat, bo);
        n_checks++;
        if (result !== 64'h5555_5555_5555_5555 || lat != 64)
            $display("FAIL divu_big: got res=%h lat=%0d, want 5555555555555555 lat=64", result, lat);
        else n_pass++;
        consume();
`else
        issue(OP_DIVU, 64'd100, 64'd7, lat, bo);
        n_checks++;
        if ({result, cout, illegal} !== {64'h0, 1'b0, 1'b1} || lat != 1)
            $display("FAIL divu_off: got res=%h c=%b il=%b lat=%0d, want 0 c=0 il=1 lat=1", result, cout, illegal, lat);
        else n_pass++;
        consume();
        issue(OP_REMU, 64'd100, 64'd7, lat, bo);
        n_checks++;
        if ({result, cout, illegal} !== {64'h0, 1'b0, 1'b1} || lat != 1)
            $display("FAIL remu_off: got res=%h c=%b il=%b lat=%0d, want 0 c=0 il=1 lat=1", result, cout, illegal, lat);
        else n_pass++;
        consume();
`endif
    endtask

    task automatic test_illegal();
        int   lat;
        logic bo;
        logic [4:0] ops[2];
        ops[0] = 5'h14;
        ops[1] = 5'h1F;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 64'h7FFF_FFFF_FFFF_FFFF, 64'h20, lat, bo);
            n_checks++;
            if ({result, cout, zero, illegal} !== {64'h0, 3'b011} || lat != 1)
                $display("FAIL illegal op=%0h: got res=%h c=%b z=%b il=%b lat=%0d, want 0 c=0 z=1 il=1 lat=1",
                         ops[i], result, cout, zero, illegal, lat);
            else n_pass++;
            consume();
        end
    endtask

    task automatic test_stall();
        int   lat;
        logic bo;
        issue(OP_ADD, 64'd40, 64'd2, lat, bo);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({out_valid, in_ready, result, cout} !== {1'b1, 1'b0, 64'd42, 1'b0})
                $display("FAIL stall cyc=%0d: got vld=%b rdy=%b res=%h c=%b, want vld=1 rdy=0 res=2a c=0",
                         i, out_valid, in_ready, result, cout);
            else n_pass++;
            @(negedge clk);
        end
        // New ADD offered in the same cycle the consumer takes the old result.
        out_ready = 1'b1;
        opcode    = OP_ADD;
        A         = 64'd3;
        B         = 64'd4;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        n_checks++;
        if ({out_valid, result} !== {1'b1, 64'd7})
            $display("FAIL stall_handoff: got vld=%b res=%h, want vld=1 res=7", out_valid, result);
        else n_pass++;
        consume();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL stall_drain: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] e;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            opcode   = OP_ADD;
            A        = 64'(k * 10);
            B        = 64'(k + 1);
            in_valid = 1'b1;
            exp_q.push_back(64'(11 * k + 1));
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({out_valid, in_ready, result} !== {2'b11, e})
                $display("FAIL b2b k=%0d: got vld=%b rdy=%b res=%h, want vld=1 rdy=1 res=%h",
                         k, out_valid, in_ready, result, e);
            else n_pass++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL b2b_drain: got vld=%b, want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic bo;
        opcode   = OP_MUL;
        A        = 64'd3;
        B        = 64'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready} !== 2'b00)
            $display("FAIL mid_busy: got vld=%b rdy=%b, want vld=0 rdy=0", out_valid, in_ready);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, result, cout, zero, illegal} !== {2'b01, 64'h0, 3'b000})
            $display("FAIL mid_reset: got vld=%b rdy=%b res=%h c=%b z=%b il=%b, want vld=0 rdy=1 res=0 c=0 z=0 il=0",
                     out_valid, in_ready, result, cout, zero, illegal);
        else n_pass++;
        repeat (70) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL mid_discard: got vld=%b, want 0 (aborted result must not appear)", out_valid);
        else n_pass++;
        issue(OP_ADD, 64'd1, 64'd1, lat, bo);
        n_checks++;
        if (result !== 64'd2 || lat != 1)
            $display("FAIL mid_after: got res=%h lat=%0d, want 2 lat=1", result, lat);
        else n_pass++;
        consume();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        A         = '0;
        B         = '0;
        @(negedge clk);
        test_reset();
        test_legacy();
        test_mul();
        test_div();
        test_illegal();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
